// File: rtl/mu.sv
// mu: sequential unsigned shift-add multiplier, one multiplier bit per clock.
// A start accepted in IDLE runs for BIT_WIDTH cycles. The full 2*BIT_WIDTH-bit
// product lands in c together with a one-cycle done strobe.
module mu #(
   parameter int unsigned BIT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [BIT_WIDTH-1:0]   a,
   input  logic [BIT_WIDTH-1:0]   b,
   input  logic                   start,
   output logic [2*BIT_WIDTH-1:0] c,
   output logic                   done
);

   localparam int unsigned PW = 2 * BIT_WIDTH;
   localparam int unsigned CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(BIT_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                 state_q,  state_d;
   logic [CW-1:0]          cnt_q,    cnt_d;
   logic [PW-1:0]          mcand_q,  mcand_d;
   logic [BIT_WIDTH-1:0]   mplier_q, mplier_d;
   logic [PW-1:0]          acc_q,    acc_d;
   logic [PW-1:0]          c_q,      c_d;
   logic                   done_q,   done_d;

   logic [PW-1:0]          pp_c;
   logic [PW-1:0]          sum_c;

   // Partial product for the current multiplier bit and the running sum.
   // mcand_q is already shifted left by the bit index, so no barrel shifter is needed.
   always_comb begin
      pp_c  = mplier_q[0] ? mcand_q : '0;
      sum_c = acc_q + pp_c;
   end

   // Next-state and datapath update for the IDLE -> BUSY -> DONE sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      c_d      = c_q;
      done_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               mcand_d  = {{BIT_WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_BUSY;
            end
         end

         ST_BUSY: begin
            acc_d    = sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               c_d     = sum_c;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         c_q      <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         c_q      <= c_d;
         done_q   <= done_d;
      end
   end

   assign c    = c_q;
   assign done = done_q;

endmodule

// File: tb/tb_mu.sv
// tb_mu: self-checking bench for mu against a plain-arithmetic product model.
module tb_mu;

   localparam int unsigned W   = 32;
   localparam int unsigned LAT = W;       // accept edge to done edge
   localparam int unsigned GAP = W + 2;   // spacing of back-to-back accepts

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [W-1:0]    a = '0;
   logic [W-1:0]    b = '0;
   logic            start = 1'b0;
   logic [2*W-1:0]  c;
   logic            done;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Last product the model expects to see on c.
   logic [2*W-1:0] model_c = '0;

   mu #(.BIT_WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .start (start),
      .c     (c),
      .done  (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      return {{W{1'b0}}, x} * {{W{1'b0}}, y};
   endfunction

   // One operation from IDLE: checks latency, that c holds during BUSY,
   // the final product and the single-cycle done pulse.
   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
      int k;
      bit hold_ok;
      bit early;
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(negedge clk);            // accept edge has passed
      start = 1'b0;
      a = $urandom; b = $urandom; // must not disturb the operation in flight
      k = 0; hold_ok = 1'b1; early = 1'b0;
      while (!done && k < LAT + 8) begin
         if (c !== model_c) hold_ok = 1'b0;
         @(negedge clk);
         k++;
         if (k % 7 == 0) begin a = $urandom; b = $urandom; end
      end
      if (!done) early = 1'b1;
      check({tag, "_timeout"}, 64'(early), 64'd0);
      check({tag, "_latency"}, 64'(k), 64'(LAT));
      check({tag, "_hold"}, 64'(hold_ok), 64'd1);
      model_c = ref_mul(av, bv);
      check({tag, "_c"}, c, model_c);
      @(negedge clk);
      check({tag, "_done_width"}, 64'(done), 64'd0);
      check({tag, "_c_after"}, c, model_c);
   endtask

   initial begin
      int t_prev;
      int k;
      bit seen_done;
      logic [W-1:0] ra, rb;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_c", c, '0);
      check("reset_done", 64'(done), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_c", c, '0);
      check("idle_done", 64'(done), 64'd0);

      // Directed cases
      run_op("one_x5", 32'h1, 32'h5);
      run_op("nine_x9", 32'h9, 32'h9);   // c must hold 5 during BUSY
      run_op("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("max_max_const", c, 64'hFFFF_FFFE_0000_0001);
      run_op("zero_a", 32'h0, 32'h1234_5678);
      run_op("msb_x2", 32'h8000_0000, 32'h2);
      check("msb_x2_const", c, 64'h1_0000_0000);

      // Back-to-back with start held high; a/b scrambled during BUSY
      @(negedge clk);
      a = 32'd7; b = 32'd6; start = 1'b1;
      @(negedge clk);
      a = $urandom; b = $urandom;
      t_prev = -1;
      for (int p = 0; p < 4; p++) begin
         k = 0;
         while (!done && k < GAP + 8) begin @(negedge clk); k++; end
         check($sformatf("b2b_seen%0d", p), 64'(done), 64'd1);
         check($sformatf("b2b_c%0d", p), c, 64'd42);
         if (t_prev >= 0) check($sformatf("b2b_gap%0d", p), 64'(cyc - t_prev), 64'(GAP));
         t_prev = cyc;
         a = 32'd7; b = 32'd6;
         if (p == 3) start = 1'b0;
         @(negedge clk);
         if (p < 3) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
         end
      end
      model_c = 64'd42;
      check("b2b_idle_done", 64'(done), 64'd0);

      // Reset 10 cycles into BUSY: immediate clear, no done for the aborted op
      a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_c", c, '0);
      check("abort_done", 64'(done), 64'd0);
      model_c = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (LAT + 4) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);
      check("abort_c_idle", c, '0);
      run_op("three_x4", 32'd3, 32'd4);

      // Randomized operands, with some corner values mixed in
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = '0;
            1: rb = '1;
            2: ra = 32'h8000_0000;
            default: ;
         endcase
         run_op($sformatf("rnd%0d", i), ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mu.md
Name: mu

Overview:
- Sequential unsigned integer multiplier for the HE datapath.
- Computes c = a * b using one shift-add step per clock, with a start/done handshake.
- The full 2*BIT_WIDTH-bit product is produced with no truncation.
- Used by the higher-level HE arithmetic blocks as a compact, fixed-latency multiplier.

Parameters:
- BIT_WIDTH, default `BIT_WIDTH from he_headers.sv (32): operand width. The product width is 2*BIT_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a  input  BIT_WIDTH  multiplicand, unsigned; sampled only when a start is accepted.
- b  input  BIT_WIDTH  multiplier, unsigned; sampled only when a start is accepted.
- start  input  1  level request; accepted on a rising edge while in IDLE.
- c  output  2*BIT_WIDTH  product register; holds the last completed result.
- done  output  1  one-cycle completion strobe; c is valid whenever done=1.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async assert, any state):
  - state=IDLE.
  - c=0, done=0.
  - Internal accumulator, shifted operand copies and bit counter cleared.
- State machine:
  - IDLE: on an edge with start=1, latch a and b into internal registers, clear the accumulator, set counter=0, go to BUSY. With start=0, remain in IDLE.
  - BUSY: each edge processes one multiplier bit, LSB first:
    - if the current multiplier bit is 1, acc += multiplicand shifted left by counter;
    - counter increments.
  - BUSY -> DONE: on the edge that processes bit BIT_WIDTH-1, write the final sum into c, set done=1 and go to DONE.
  - DONE: lasts exactly one cycle. On the next edge, done=0 and state returns to IDLE.
- Latency:
  - Start accepted at edge E0; done=1 and c valid after edge E_BIT_WIDTH (32 cycles for the default width).
  - Latency is fixed; there is no early termination on zero operands.
- Back-to-back operation:
  - If start is still 1 when the block is back in IDLE (one edge after DONE), a new operation is accepted.
  - Minimum spacing between accepted starts is therefore BIT_WIDTH+2 cycles.
- start is ignored in BUSY and DONE. Changes on a or b after acceptance do not affect the result in progress.
- c changes only on the completion edge or on reset. It holds its value through IDLE and BUSY of later operations until the next completion overwrites it.
- Arithmetic:
  - Unsigned operands; exact 2*BIT_WIDTH-bit product with no overflow possible.
  - The accumulator is 2*BIT_WIDTH bits wide.
- Reset asserted mid-operation aborts the operation: outputs return to their reset values and no done pulse is issued for the aborted operation.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset, then start with a=32'h1, b=32'h5 held -> done pulses 32 cycles after acceptance with c=64'h5; done stays high for exactly 1 cycle.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> c=64'hFFFFFFFE00000001 at done.
- a=32'h0, b=32'h12345678 -> done still at the full 32-cycle latency with c=0. Then a=32'h80000000, b=32'h2 -> c=64'h1_00000000.
- Hold start=1 continuously with a=7, b=6 -> done pulses every 34 cycles with c=42 each time. Change a/b during BUSY -> the in-flight result is unaffected.
- Assert rst 10 cycles into BUSY -> c=0 and done=0 immediately (asynchronous). Deassert rst, start again with 3*4 -> c=12 after 32 cycles.
- After a completion with c=64'h5, start 9*9 -> c stays 5 during BUSY and becomes 81 only on the done cycle.
